sha256_compress: RTL and testbench
==================================

# sha256_compress

SHA-256 compression engine: the consumer of the Wt word stream produced by the message scheduler. It accepts one Wt word per round over a valid/ready handshake and runs the 64 compression rounds on working variables a..h. It then folds the result into the chained hash state H0..H7 and presents the 256-bit digest. It sits between the message scheduler and the accelerator's host-facing output register.

## Interface
- No parameters; word width 32 and round count 64 are fixed by SHA-256.
- clk_i  in  1  clock; all state updates on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- start_i  in  1  begin compressing one 512-bit block; sampled only in IDLE
- first_block_i  in  1  sampled with start_i; 1 = load the FIPS 180-4 IV, 0 = chain from the current H
- wt_i  in  32  message schedule word W[t]
- wt_valid_i  in  1  wt_i valid
- wt_ready_o  out  1  engine accepts wt_i this cycle
- busy_o  out  1  block in progress (ROUND or FINAL)
- digest_o  out  256  {H0,...,H7}; H0 is in [255:224]
- digest_valid_o  out  1  digest_o holds the result of the last completed block

## Operation
- States:
  - IDLE: on start_i, go to ROUND with t=0.
    - If first_block_i=1: H<=IV and a..h<=IV.
    - Else: a..h<=H.
    - digest_valid_o<=0.
  - ROUND: wt_ready_o=1. Each handshake (wt_valid_i & wt_ready_o):
    - T1=h+Σ1(e)+Ch(e,f,g)+K[t]+wt_i
    - T2=Σ0(a)+Maj(a,b,c)
    - h..a <= g,f,e,d+T1,c,b,a,T1+T2
    - t<=t+1
    - When the handshake occurs with t=63, go to FINAL.
  - FINAL: Hi<=Hi+{a..h}[i] for each i; digest_valid_o<=1; go to IDLE.
- Round functions:
  - Σ0(x)=ROTR2^ROTR13^ROTR22
  - Σ1(x)=ROTR6^ROTR11^ROTR25
  - Ch=(e&f)^(~e&g)
  - Maj=(a&b)^(a&c)^(b&c)
  - These use rotations, not shifts.
- All additions are modulo 2^32 per word; carries are discarded.
- Without wt_valid_i, ROUND holds; a..h and t are unchanged.
- wt_ready_o=0 in IDLE and FINAL. Words presented there are not consumed.
- start_i in ROUND or FINAL is ignored; it is not queued.
- digest_o always reflects the H registers. It changes only in FINAL or on a first-block load.
- Chaining (first_block_i=0) directly after reset chains from H=0. This is defined behaviour, not an error.

## Timing
- Reset values:
  - state=IDLE, t=0, a..h=0, H=0.
  - digest_o=0, digest_valid_o=0, wt_ready_o=0, busy_o=0.
- Reset asserted mid-block aborts the block immediately. No partial digest is committed.
- Round timing with start accepted in cycle N:
  - The first word can be accepted in cycle N+1.
  - With wt_valid_i held high, rounds occupy N+1..N+64.
  - FINAL occupies N+65.
  - digest_valid_o=1 from N+66.
  - A new start_i is accepted at N+66 at the earliest.
- Minimum block throughput is 66 cycles. Each stalled cycle adds one cycle.
- busy_o=1 from N+1 through N+65.
- digest_valid_o stays high until the next accepted start_i. It is low from the cycle after that start.

## Structure
- Package sha256_pkg holds:
  - K[0:63] round constant table
  - IV H0..H7 constants
  - FSM state enum (IDLE, ROUND, FINAL)
  - word width localparam
- Sub-module sha256_round: purely combinational. Inputs are a..h, K[t] and wt. Outputs are next a..h. Σ0, Σ1, Ch and Maj live inside it.
- The top level holds the FSM, the 6-bit t counter, a..h, H and the handshake logic.

## Test plan
- "abc" block: start_i with first_block_i=1, then feed W0..W63 from the golden model (W0=61626380, W15=00000018) with valid held high.
  - Required: digest_o=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
  - Required: digest_valid_o rises exactly 66 cycles after the start cycle.
- Empty message (W0=80000000, W15=0):
  - Required: digest_o=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": second block started with first_block_i=0.
  - Required: digest_o=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- Backpressure: repeat "abc" with wt_valid_i randomly deasserted about 50% of the time.
  - Required: same digest.
  - Required: exactly 64 handshakes.
  - Required: latency = 66 + number of stall cycles.
- Reset mid-block: assert rst_n_i=0 at round 30.
  - Required: all outputs zero immediately.
  - Required: a following "abc" block still yields ba7816bf...f20015ad.
- Start while busy: pulse start_i at round 10 with first_block_i=1.
  - Required: ignored; busy_o stays 1 and the digest is unchanged from the no-pulse run.
  - Required: wt_ready_o=0 in IDLE with wt_valid_i=1.

Source files
------------

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha256_pkg
// Brief    : SHA-256 compression constants, types and rotate helper.
// Revision : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    localparam int c_WORD_W = 32;
    localparam int c_ROUNDS = 64;

    typedef logic [c_WORD_W-1:0] word_t;

    // Working variables; 'a' occupies the most significant word.
    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } wv_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [255:0] c_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t c_K [0:c_ROUNDS-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (c_WORD_W - n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_round.sv
`default_nettype none
// ============================================================================
// Module   : sha256_round
// Brief    : One combinational SHA-256 compression round.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_round
    import sha256_pkg::*;
(
    input  wv_t   wv_i,
    input  word_t k_i,
    input  word_t wt_i,
    output wv_t   wv_o
);

    word_t w_sig0;
    word_t w_sig1;
    word_t w_ch;
    word_t w_maj;
    word_t w_t1;
    word_t w_t2;

    always_comb begin
        w_sig0 = rotr(wv_i.a, 2) ^ rotr(wv_i.a, 13) ^ rotr(wv_i.a, 22);
        w_sig1 = rotr(wv_i.e, 6) ^ rotr(wv_i.e, 11) ^ rotr(wv_i.e, 25);
        w_ch   = (wv_i.e & wv_i.f) ^ (~wv_i.e & wv_i.g);
        w_maj  = (wv_i.a & wv_i.b) ^ (wv_i.a & wv_i.c) ^ (wv_i.b & wv_i.c);
        w_t1   = wv_i.h + w_sig1 + w_ch + k_i + wt_i;
        w_t2   = w_sig0 + w_maj;

        wv_o.a = w_t1 + w_t2;
        wv_o.b = wv_i.a;
        wv_o.c = wv_i.b;
        wv_o.d = wv_i.c;
        wv_o.e = wv_i.d + w_t1;
        wv_o.f = wv_i.e;
        wv_o.g = wv_i.f;
        wv_o.h = wv_i.g;
    end

endmodule
`default_nettype wire

// File: rtl/sha256_compress.sv
`default_nettype none
// ============================================================================
// Module   : sha256_compress
// Brief    : SHA-256 compression engine consuming one Wt word per round.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_compress
    import sha256_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic         first_block_i,
    input  logic [31:0]  wt_i,
    input  logic         wt_valid_i,
    output logic         wt_ready_o,
    output logic         busy_o,
    output logic [255:0] digest_o,
    output logic         digest_valid_o
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [5:0]       r_t;
    wv_t              r_wv;
    wv_t              w_wv_nxt;
    logic [7:0][31:0] r_h;        // r_h[7] is H0 so the digest is a direct view
    logic [7:0][31:0] w_wv_words;
    logic             r_digest_valid;
    logic             w_hs;

    sha256_round u_round (
        .wv_i (r_wv),
        .k_i  (c_K[r_t]),
        .wt_i (wt_i),
        .wv_o (w_wv_nxt)
    );

    assign w_hs       = wt_valid_i && (r_state == ROUND);
    assign w_wv_words = r_wv;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_i) w_state_nxt = ROUND;
            ROUND:   if (w_hs && (r_t == 6'(c_ROUNDS - 1))) w_state_nxt = FINAL;
            FINAL:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_t            <= '0;
            r_wv           <= '0;
            r_h            <= '0;
            r_digest_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_t            <= '0;
                        r_digest_valid <= 1'b0;
                        if (first_block_i) begin
                            r_h  <= c_IV;
                            r_wv <= wv_t'(c_IV);
                        end else begin
                            r_wv <= wv_t'(r_h);
                        end
                    end
                end
                ROUND: begin
                    if (w_hs) begin
                        r_wv <= w_wv_nxt;
                        r_t  <= r_t + 6'd1;
                    end
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        r_h[i] <= r_h[i] + w_wv_words[i];
                    end
                    r_digest_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wt_ready_o     = (r_state == ROUND);
    assign busy_o         = (r_state != IDLE);
    assign digest_o       = r_h;
    assign digest_valid_o = r_digest_valid;

endmodule
`default_nettype wire

// File: tb/tb_sha256_compress.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_compress
// Brief    : Self-checking bench for sha256_compress with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_compress;
    import sha256_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_n_i = 1'b0;
    logic         start_i = 1'b0;
    logic         first_block_i = 1'b0;
    logic [31:0]  wt_i = '0;
    logic         wt_valid_i = 1'b0;
    logic         wt_ready_o;
    logic         busy_o;
    logic [255:0] digest_o;
    logic         digest_valid_o;

    int           errors = 0;
    int           checks = 0;
    logic [31:0]  sched [64];
    logic [255:0] model_h;

    localparam logic [255:0] c_ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] c_TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] c_ABC_BLK   = {"abc", 8'h80, 416'h0, 64'h18};

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         has_exp;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs [4];

    always #5 clk_i = ~clk_i;

    sha256_compress dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .start_i        (start_i),
        .first_block_i  (first_block_i),
        .wt_i           (wt_i),
        .wt_valid_i     (wt_valid_i),
        .wt_ready_o     (wt_ready_o),
        .busy_o         (busy_o),
        .digest_o       (digest_o),
        .digest_valid_o (digest_valid_o)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message schedule of a 512-bit block, straight from the standard's recurrence.
    task automatic expand(input logic [511:0] blk);
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) sched[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(sched[i-15], 7) ^ rr(sched[i-15], 18) ^ (sched[i-15] >> 3);
            s1 = rr(sched[i-2], 17) ^ rr(sched[i-2], 19) ^ (sched[i-2] >> 10);
            sched[i] = sched[i-16] + s0 + sched[i-7] + s1;
        end
    endtask

    function automatic logic [255:0] ref_compress(input logic [255:0] hin);
        logic [31:0] v [8];
        logic [31:0] hh [8];
        logic [31:0] t1, t2, ch, mj, bs0, bs1;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            hh[i] = hin[255 - 32*i -: 32];
            v[i]  = hh[i];
        end
        for (int t = 0; t < 64; t++) begin
            bs1 = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
            bs0 = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
            ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
            mj  = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t1  = v[7] + bs1 + ch + c_K[t] + sched[t];
            t2  = bs0 + mj;
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hh[i] + v[i];
        return r;
    endfunction

    // Drives one block; stall_pct sets the chance of withholding a word,
    // pulse_at >= 0 raises start_i while that round's word is pending.
    task automatic run_block(input logic [511:0] blk, input logic first, input int stall_pct,
                             input int pulse_at, output int lat, output int hs,
                             output int stalls, output logic busy_ok);
        int   guard;
        logic rdy;
        expand(blk);
        @(negedge clk_i);
        start_i       = 1'b1;
        first_block_i = first;
        wt_valid_i    = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        lat = 1; hs = 0; stalls = 0; busy_ok = 1'b1; guard = 0;
        while (digest_valid_o !== 1'b1 && guard < 2000) begin
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            rdy           = wt_ready_o;
            wt_valid_i    = ($urandom_range(99) >= stall_pct);
            wt_i          = (hs < 64) ? sched[hs] : $urandom;
            start_i       = (pulse_at >= 0) && (hs == pulse_at) && rdy;
            first_block_i = (pulse_at >= 0) ? 1'b1 : first;
            if (rdy && wt_valid_i) hs++;
            else if (rdy) stalls++;
            @(negedge clk_i);
            lat++;
            guard++;
        end
        start_i    = 1'b0;
        wt_valid_i = 1'b0;
        if (guard >= 2000) begin
            checks++;
            errors++;
            $display("FAIL block_timeout: digest_valid_o never rose, got %0d cycles", guard);
        end
        check("busy_after_final", 256'(busy_o), 256'(0));
        check("ready_after_final", 256'(wt_ready_o), 256'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0t", $time);
        $fatal(1);
    end

    initial begin
        int           lat, hs, st;
        logic         bok;
        logic [511:0] rblk;
        logic         rfirst;

        vecs[0] = '{blk: c_ABC_BLK, first: 1'b1, has_exp: 1'b1, exp: c_ABC_DIG};
        vecs[1] = '{blk: {8'h80, 440'h0, 64'h0}, first: 1'b1, has_exp: 1'b1, exp: c_EMPTY_DIG};
        vecs[2] = '{blk: {"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 8'h80, 56'h0},
                    first: 1'b1, has_exp: 1'b0, exp: '0};
        vecs[3] = '{blk: {480'h0, 32'h000001c0}, first: 1'b0, has_exp: 1'b1, exp: c_TWO_DIG};

        repeat (3) @(negedge clk_i);
        check("reset_digest", digest_o, '0);
        check("reset_valid", 256'(digest_valid_o), 256'(0));
        check("reset_ready", 256'(wt_ready_o), 256'(0));
        check("reset_busy", 256'(busy_o), 256'(0));
        rst_n_i = 1'b1;
        model_h = '0;

        // Known-answer table, full throughput
        for (int i = 0; i < 4; i++) begin
            run_block(vecs[i].blk, vecs[i].first, 0, -1, lat, hs, st, bok);
            model_h = ref_compress(vecs[i].first ? c_IV : model_h);
            check("table_digest_model", digest_o, model_h);
            if (vecs[i].has_exp) check("table_digest_golden", digest_o, vecs[i].exp);
            check("table_latency", 256'(lat), 256'(66));
            check("table_handshakes", 256'(hs), 256'(64));
            check("table_busy", 256'(bok), 256'(1));
        end

        // Backpressure on "abc"
        run_block(c_ABC_BLK, 1'b1, 50, -1, lat, hs, st, bok);
        model_h = ref_compress(c_IV);
        check("bp_digest", digest_o, c_ABC_DIG);
        check("bp_handshakes", 256'(hs), 256'(64));
        check("bp_latency", 256'(lat), 256'(66 + st));
        check("bp_busy", 256'(bok), 256'(1));

        // Words offered in IDLE must not be taken
        @(negedge clk_i);
        wt_valid_i = 1'b1;
        wt_i       = $urandom;
        @(negedge clk_i);
        check("idle_ready", 256'(wt_ready_o), 256'(0));
        check("idle_busy", 256'(busy_o), 256'(0));
        check("idle_digest", digest_o, model_h);
        check("idle_valid", 256'(digest_valid_o), 256'(1));
        wt_valid_i = 1'b0;

        // start_i pulsed mid-block must be ignored; chain from current H
        for (int j = 0; j < 16; j++) rblk[32*j +: 32] = $urandom;
        run_block(rblk, 1'b0, 20, 10, lat, hs, st, bok);
        model_h = ref_compress(model_h);
        check("busy_pulse_digest", digest_o, model_h);
        check("busy_pulse_busy", 256'(bok), 256'(1));
        check("busy_pulse_latency", 256'(lat), 256'(66 + st));

        // Random blocks, random chaining and stalls
        for (int n = 0; n < 5; n++) begin
            for (int j = 0; j < 16; j++) rblk[32*j +: 32] = $urandom;
            rfirst = 1'($urandom_range(1));
            run_block(rblk, rfirst, 25, -1, lat, hs, st, bok);
            model_h = ref_compress(rfirst ? c_IV : model_h);
            check("rand_digest", digest_o, model_h);
            check("rand_handshakes", 256'(hs), 256'(64));
            check("rand_latency", 256'(lat), 256'(66 + st));
        end

        // Reset in round 30
        expand(c_ABC_BLK);
        @(negedge clk_i);
        start_i       = 1'b1;
        first_block_i = 1'b1;
        @(negedge clk_i);
        start_i    = 1'b0;
        wt_valid_i = 1'b1;
        for (int k = 0; k < 30; k++) begin
            wt_i = sched[k];
            @(negedge clk_i);
        end
        rst_n_i = 1'b0;
        #1;
        check("midrst_digest", digest_o, '0);
        check("midrst_valid", 256'(digest_valid_o), 256'(0));
        check("midrst_ready", 256'(wt_ready_o), 256'(0));
        check("midrst_busy", 256'(busy_o), 256'(0));
        wt_valid_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        model_h = '0;

        // Chaining straight after reset starts from H=0
        for (int j = 0; j < 16; j++) rblk[32*j +: 32] = $urandom;
        run_block(rblk, 1'b0, 0, -1, lat, hs, st, bok);
        model_h = ref_compress(model_h);
        check("chain_zero_digest", digest_o, model_h);

        run_block(c_ABC_BLK, 1'b1, 0, -1, lat, hs, st, bok);
        check("post_rst_abc", digest_o, c_ABC_DIG);
        check("post_rst_latency", 256'(lat), 256'(66));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
